// File: rtl/nway_trace_repository_datatypes_pkg.sv
// Shared types for the trace repository active set: slot state encoding,
// slot record layout and default sizing.
package nway_trace_repository_datatypes;

    localparam int AS_DEPTH_DEFAULT = 4;
    localparam int AS_ADDR_W        = 32;
    localparam int AS_IDX_W         = 17;   // $clog2(131072) trace entries

    typedef enum logic [1:0] {
        MAKE_REQUEST        = 2'd0,
        WAIT_FOR_PROCESSING = 2'd1,
        REQUEST_RETIRED     = 2'd2
    } active_set_state_t;

    typedef struct packed {
        logic                  occupied;
        active_set_state_t     state;
        logic [AS_ADDR_W-1:0]  mem_addr;
        logic [AS_IDX_W-1:0]   trace_index;
        logic                  hit;
    } active_set_slot_t;

endpackage

// File: rtl/nway_active_set_scheduler.sv
// In-order active set between the trace repository and the N-way cache:
// allocates slots, issues cache requests, collects responses, retires in order.
module nway_active_set_scheduler
    import nway_trace_repository_datatypes::*;
#(
    parameter int ACTIVE_SET_DEPTH  = AS_DEPTH_DEFAULT,
    parameter int DATA_ADDR_WIDTH   = AS_ADDR_W,
    parameter int TRACE_INDEX_WIDTH = AS_IDX_W,
    localparam int PTR_W = $clog2(ACTIVE_SET_DEPTH),
    localparam int OCC_W = $clog2(ACTIVE_SET_DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enq_valid,
    output logic                         enq_ready,
    input  logic [TRACE_INDEX_WIDTH-1:0] enq_trace_index,
    input  logic [DATA_ADDR_WIDTH-1:0]   enq_mem_addr,
    output logic                         cache_req,
    output logic [DATA_ADDR_WIDTH-1:0]   cache_addr,
    input  logic                         cache_gnt,
    input  logic                         cache_rvalid,
    input  logic                         cache_hit,
    output logic                         ret_valid,
    input  logic                         ret_ready,
    output logic [TRACE_INDEX_WIDTH-1:0] ret_trace_index,
    output logic                         ret_hit_miss,
    output logic [OCC_W-1:0]             occupancy
);

    active_set_slot_t   slots_q [ACTIVE_SET_DEPTH];
    logic [PTR_W-1:0]   wr_q, iss_q, rsp_q, rd_q;
    logic [OCC_W-1:0]   occ_q;
    logic               seen_gnt_q;

    logic enq_fire, gnt_fire, rsp_fire, ret_fire;

    // Ready comes straight from the registered count: a retire never frees
    // a slot for an enqueue in the same cycle.
    assign enq_ready = (occ_q < OCC_W'(ACTIVE_SET_DEPTH));
    assign enq_fire  = enq_valid & enq_ready;

    assign cache_req  = slots_q[iss_q].occupied & (slots_q[iss_q].state == MAKE_REQUEST);
    assign cache_addr = slots_q[iss_q].mem_addr;
    assign gnt_fire   = cache_req & cache_gnt;

    assign rsp_fire = cache_rvalid & slots_q[rsp_q].occupied
                    & (slots_q[rsp_q].state == WAIT_FOR_PROCESSING);

    assign ret_valid       = slots_q[rd_q].occupied & (slots_q[rd_q].state == REQUEST_RETIRED);
    assign ret_trace_index = slots_q[rd_q].trace_index;
    assign ret_hit_miss    = slots_q[rd_q].hit;
    assign ret_fire        = ret_valid & ret_ready;

    assign occupancy = occ_q;

    // The four events always land on distinct slots, so they update independently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ACTIVE_SET_DEPTH; i++) slots_q[i] <= '0;
        end else begin
            if (enq_fire) begin
                slots_q[wr_q].occupied    <= 1'b1;
                slots_q[wr_q].state       <= MAKE_REQUEST;
                slots_q[wr_q].mem_addr    <= enq_mem_addr;
                slots_q[wr_q].trace_index <= enq_trace_index;
                slots_q[wr_q].hit         <= 1'b0;
            end
            if (gnt_fire) slots_q[iss_q].state <= WAIT_FOR_PROCESSING;
            if (rsp_fire) begin
                slots_q[rsp_q].state <= REQUEST_RETIRED;
                slots_q[rsp_q].hit   <= cache_hit;
            end
            if (ret_fire) slots_q[rd_q].occupied <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q       <= '0;
            iss_q      <= '0;
            rsp_q      <= '0;
            rd_q       <= '0;
            occ_q      <= '0;
            seen_gnt_q <= 1'b0;
        end else begin
            if (enq_fire) wr_q  <= wr_q  + PTR_W'(1);
            if (gnt_fire) iss_q <= iss_q + PTR_W'(1);
            if (rsp_fire) rsp_q <= rsp_q + PTR_W'(1);
            if (ret_fire) rd_q  <= rd_q  + PTR_W'(1);
            case ({enq_fire, ret_fire})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
            seen_gnt_q <= seen_gnt_q | gnt_fire;
        end
    end

    // Responses left over from before a reset are dropped silently; once a
    // request has been granted, every response must match a waiting slot.
    a_rvalid_matches_wait: assert property (@(posedge clk) disable iff (!rst_n)
        (cache_rvalid && seen_gnt_q) |-> rsp_fire);

endmodule

// File: tb/tb_nway_active_set_scheduler.sv
// Bench for nway_active_set_scheduler: per-cycle vector tables for latency and
// full-set corners, plus a cache model and in-order retire scoreboard.
module tb_nway_active_set_scheduler;
    import nway_trace_repository_datatypes::*;

    localparam int D  = 4;
    localparam int AW = 32;
    localparam int IW = 17;
    localparam int OW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enq_valid, enq_ready;
    logic [IW-1:0] enq_trace_index;
    logic [AW-1:0] enq_mem_addr;
    logic          cache_req;
    logic [AW-1:0] cache_addr;
    logic          cache_gnt, cache_rvalid, cache_hit;
    logic          ret_valid, ret_ready;
    logic [IW-1:0] ret_trace_index;
    logic          ret_hit_miss;
    logic [OW-1:0] occupancy;

    nway_active_set_scheduler #(
        .ACTIVE_SET_DEPTH(D), .DATA_ADDR_WIDTH(AW), .TRACE_INDEX_WIDTH(IW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_trace_index(enq_trace_index), .enq_mem_addr(enq_mem_addr),
        .cache_req(cache_req), .cache_addr(cache_addr), .cache_gnt(cache_gnt),
        .cache_rvalid(cache_rvalid), .cache_hit(cache_hit),
        .ret_valid(ret_valid), .ret_ready(ret_ready),
        .ret_trace_index(ret_trace_index), .ret_hit_miss(ret_hit_miss),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] idx;
        logic          hit;
    } exp_t;

    typedef struct {
        bit            ev;
        logic [IW-1:0] idx;
        logic [AW-1:0] addr;
        bit            gnt, rv, hit, rr;
        bit            x_req;
        logic [AW-1:0] x_addr;
        bit            x_rv;
        logic [IW-1:0] x_idx;
        bit            x_hit;
        logic [OW-1:0] x_occ;
        bit            x_rdy;
    } vec_t;

    int            n_chk = 0;
    int            n_fail = 0;
    int            n_ret = 0;
    logic [IW-1:0] next_idx;
    exp_t          exp_q[$];
    logic [IW-1:0] issq[$];
    logic [IW-1:0] rspq[$];
    vec_t          t1[5];
    vec_t          t2[10];

    function automatic logic hit_of(input logic [IW-1:0] i);
        return i[0];
    endfunction

    function automatic vec_t mk(input bit ev, input int idx, input int addr,
                                input bit g, input bit rv, input bit h, input bit rr,
                                input bit xreq, input int xaddr, input bit xrv,
                                input int xidx, input bit xhit, input int xocc, input bit xrdy);
        vec_t v;
        v.ev = ev; v.idx = IW'(idx); v.addr = AW'(addr);
        v.gnt = g; v.rv = rv; v.hit = h; v.rr = rr;
        v.x_req = xreq; v.x_addr = AW'(xaddr); v.x_rv = xrv;
        v.x_idx = IW'(xidx); v.x_hit = xhit; v.x_occ = OW'(xocc); v.x_rdy = xrdy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        enq_valid = 0; enq_trace_index = '0; enq_mem_addr = '0;
        cache_gnt = 0; cache_rvalid = 0; cache_hit = 0; ret_ready = 0;
    endtask

    // Bookkeeping on the inputs about to be sampled, then advance one cycle.
    task automatic tick();
        exp_t e;
        if (ret_valid && ret_ready) begin
            n_ret++;
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL ret_unexpected: got idx 0x%0h with empty scoreboard", ret_trace_index);
            end else begin
                n_chk--;
                e = exp_q.pop_front();
                chk("sb_ret_idx", 64'(ret_trace_index), 64'(e.idx));
                chk("sb_ret_hit", 64'(ret_hit_miss), 64'(e.hit));
            end
        end
        if (cache_rvalid && rspq.size() > 0) void'(rspq.pop_front());
        if (cache_req && cache_gnt && issq.size() > 0) rspq.push_back(issq.pop_front());
        if (enq_valid && enq_ready) begin
            e.idx = enq_trace_index;
            e.hit = hit_of(enq_trace_index);
            exp_q.push_back(e);
            issq.push_back(enq_trace_index);
        end
        @(posedge clk);
        #1;
    endtask

    // Cache model: grants when told to, answers the oldest granted request.
    task automatic run(input int n, input bit en, input bit g, input bit rv, input bit rr);
        for (int k = 0; k < n; k++) begin
            enq_valid       = en;
            enq_trace_index = next_idx;
            enq_mem_addr    = 32'h4000 + 32'(next_idx) * 32'd4;
            cache_gnt       = g;
            cache_rvalid    = rv && (rspq.size() > 0);
            cache_hit       = (rspq.size() > 0) ? hit_of(rspq[0]) : 1'b0;
            ret_ready       = rr;
            if (en && enq_ready) next_idx = next_idx + 1'b1;
            tick();
        end
        idle();
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        chk({tag, ".cache_req"}, 64'(cache_req), 64'(v.x_req));
        if (v.x_req) chk({tag, ".cache_addr"}, 64'(cache_addr), 64'(v.x_addr));
        chk({tag, ".ret_valid"}, 64'(ret_valid), 64'(v.x_rv));
        if (v.x_rv) begin
            chk({tag, ".ret_idx"}, 64'(ret_trace_index), 64'(v.x_idx));
            chk({tag, ".ret_hit"}, 64'(ret_hit_miss), 64'(v.x_hit));
        end
        chk({tag, ".occupancy"}, 64'(occupancy), 64'(v.x_occ));
        chk({tag, ".enq_ready"}, 64'(enq_ready), 64'(v.x_rdy));
        enq_valid = v.ev; enq_trace_index = v.idx; enq_mem_addr = v.addr;
        cache_gnt = v.gnt; cache_rvalid = v.rv; cache_hit = v.hit; ret_ready = v.rr;
        tick();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".cache_req"}, 64'(cache_req), 64'd0);
        chk({tag, ".cache_addr"}, 64'(cache_addr), 64'd0);
        chk({tag, ".ret_valid"}, 64'(ret_valid), 64'd0);
        chk({tag, ".ret_idx"}, 64'(ret_trace_index), 64'd0);
        chk({tag, ".ret_hit"}, 64'(ret_hit_miss), 64'd0);
        chk({tag, ".occupancy"}, 64'(occupancy), 64'd0);
        chk({tag, ".enq_ready"}, 64'(enq_ready), 64'd1);
    endtask

    initial begin
        //              ev idx addr      g rv h rr  xreq xaddr    xrv xidx xh occ rdy
        t1[0] = mk(1, 5, 'h1000,   0, 0, 0, 0,  0, 0,        0, 0, 0, 0, 1);
        t1[1] = mk(0, 0, 0,        1, 0, 0, 0,  1, 'h1000,   0, 0, 0, 1, 1);
        t1[2] = mk(0, 0, 0,        0, 1, 1, 0,  0, 0,        0, 0, 0, 1, 1);
        t1[3] = mk(0, 0, 0,        0, 0, 0, 1,  0, 0,        1, 5, 1, 1, 1);
        t1[4] = mk(0, 0, 0,        0, 0, 0, 0,  0, 0,        0, 0, 0, 0, 1);

        t2[0] = mk(1, 21, 'h2000,  0, 0, 0, 0,  0, 0,        0, 0, 0, 0, 1);
        t2[1] = mk(1, 22, 'h2004,  0, 0, 0, 0,  1, 'h2000,   0, 0, 0, 1, 1);
        t2[2] = mk(1, 23, 'h2008,  0, 0, 0, 0,  1, 'h2000,   0, 0, 0, 2, 1);
        t2[3] = mk(1, 24, 'h200C,  0, 0, 0, 0,  1, 'h2000,   0, 0, 0, 3, 1);
        t2[4] = mk(1, 25, 'h2010,  0, 0, 0, 0,  1, 'h2000,   0, 0, 0, 4, 0);
        t2[5] = mk(0, 0, 0,        1, 0, 0, 0,  1, 'h2000,   0, 0, 0, 4, 0);
        t2[6] = mk(0, 0, 0,        1, 1, 1, 0,  1, 'h2004,   0, 0, 0, 4, 0);
        t2[7] = mk(1, 26, 'h3000,  0, 0, 0, 1,  1, 'h2008,   1, 21, 1, 4, 0);
        t2[8] = mk(1, 26, 'h3000,  0, 0, 0, 0,  1, 'h2008,   0, 0, 0, 3, 1);
        t2[9] = mk(0, 0, 0,        0, 0, 0, 0,  1, 'h2008,   0, 0, 0, 4, 0);

        idle();
        rst_n = 1'b0;
        #3;
        chk_reset_outputs("reset");
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) apply_vec(t1[i], $sformatf("single[%0d]", i));

        for (int i = 0; i < 10; i++) apply_vec(t2[i], $sformatf("full[%0d]", i));
        idle();
        run(10, 0, 1, 1, 1);
        chk("full.drained_occ", 64'(occupancy), 64'd0);
        chk("full.sb_empty", 64'(exp_q.size()), 64'd0);

        next_idx = IW'(100);
        n_ret = 0;
        run(8, 1, 1, 1, 1);
        run(3, 0, 1, 1, 1);
        chk("stream.retires_in_11", 64'(n_ret), 64'd8);
        chk("stream.accepted", 64'(next_idx), 64'd108);
        chk("stream.occ", 64'(occupancy), 64'd0);

        next_idx = IW'(41);
        n_ret = 0;
        run(4, 1, 1, 1, 0);
        run(3, 0, 1, 1, 0);
        chk("hold.ret_valid", 64'(ret_valid), 64'd1);
        chk("hold.ret_idx", 64'(ret_trace_index), 64'd41);
        chk("hold.occ", 64'(occupancy), 64'd4);
        chk("hold.no_retire", 64'(n_ret), 64'd0);
        run(4, 0, 0, 0, 1);
        chk("hold.retired", 64'(n_ret), 64'd4);
        chk("hold.occ_after", 64'(occupancy), 64'd0);

        next_idx = IW'(60);
        run(3, 1, 1, 0, 0);
        chk("inflight.occ", 64'(occupancy), 64'd3);
        chk("inflight.req", 64'(cache_req), 64'd1);
        #3 rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        exp_q.delete(); issq.delete(); rspq.delete();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        cache_rvalid = 1'b1; cache_hit = 1'b1;
        tick();
        idle();
        chk("stray.ret_valid", 64'(ret_valid), 64'd0);
        chk("stray.occ", 64'(occupancy), 64'd0);
        tick();
        chk("stray.ret_valid2", 64'(ret_valid), 64'd0);

        next_idx = IW'(70);
        n_ret = 0;
        run(1, 1, 0, 0, 0);
        run(5, 0, 1, 1, 1);
        chk("recover.retired", 64'(n_ret), 64'd1);
        chk("recover.occ", 64'(occupancy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/nway_active_set_scheduler.md
# nway_active_set_scheduler

Sequences memory requests from the trace repository's active set into the N-way cache and retires them, in order, with a hit/miss flag per trace entry. Sits between the trace repository (producer of trace index + data address pairs) and the cache's request port. Holds up to ACTIVE_SET_DEPTH in-flight entries, each moving through MAKE_REQUEST → WAIT_FOR_PROCESSING → REQUEST_RETIRED.

## Interface
- Clocking: one clock, `clk`; reset `rst_n` is asynchronous, active-low.

Parameters:
- ACTIVE_SET_DEPTH, 4: slots in the active set; power of two, ≥2.
- DATA_ADDR_WIDTH, 32: memory address width.
- TRACE_INDEX_WIDTH, 17: $clog2(TRACE_ENTRIES), with TRACE_ENTRIES = 131072.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- enq_valid  in  1  trace repository offers an entry
- enq_ready  out  1  slot free; 1 when occupancy < ACTIVE_SET_DEPTH
- enq_trace_index  in  TRACE_INDEX_WIDTH  trace slot of the entry
- enq_mem_addr  in  DATA_ADDR_WIDTH  data address to request
- cache_req  out  1  request to cache
- cache_addr  out  DATA_ADDR_WIDTH  request address
- cache_gnt  in  1  cache accepted request
- cache_rvalid  in  1  response for oldest granted request
- cache_hit  in  1  response was a hit; valid with cache_rvalid
- ret_valid  out  1  oldest entry retired and ready to write back
- ret_ready  in  1  trace repository consumes the retirement
- ret_trace_index  out  TRACE_INDEX_WIDTH  trace slot being written back
- ret_hit_miss  out  1  1 = hit, 0 = miss
- occupancy  out  $clog2(ACTIVE_SET_DEPTH+1)  occupied slots

## Operation
- Circular buffer of slots. Each slot holds: occupied, state, mem_addr, trace_index, hit flag.
- Four pointers, each log2(DEPTH) bits and wrapping modulo DEPTH: alloc (wr), issue (iss), response (rsp), retire (rd).
- Enqueue: on enq_valid & enq_ready, write slot[wr] with state MAKE_REQUEST and increment wr.
- Issue: cache_req = slot[iss].occupied & state == MAKE_REQUEST. cache_addr = slot[iss].mem_addr.
  - On cache_req & cache_gnt: state becomes WAIT_FOR_PROCESSING; iss increments.
  - cache_req and cache_addr stay stable until granted.
- Response: the cache responds in order. On cache_rvalid, slot[rsp] takes hit = cache_hit and state REQUEST_RETIRED; rsp increments.
  - cache_rvalid with no WAIT_FOR_PROCESSING slot at rsp is ignored; an assertion fires.
- Retire: ret_valid = slot[rd].occupied & state == REQUEST_RETIRED.
  - On ret_valid & ret_ready: clear occupied; rd increments.
- Occupancy: a registered counter, +1 on enqueue, −1 on retire. It is unchanged when both happen in one cycle.
- Simultaneous events are all legal in one cycle: enqueue, grant, response and retire touch distinct pointers.
- enq_ready comes from the registered occupancy, with no bypass. When full, a same-cycle retire does not allow an enqueue that cycle.
- Grant and response to the same slot in one cycle are not possible. A response arrives at the earliest one cycle after its grant.

## Timing
- Reset values: all slots unoccupied; all pointers 0; occupancy 0.
  - Outputs: cache_req 0, cache_addr 0, ret_valid 0, ret_trace_index 0, ret_hit_miss 0, enq_ready 1.
- Reset asserted mid-operation drops all in-flight entries immediately.
  - Any later cache_rvalid is ignored until a new grant.
- Latency from an empty set:
  - Enqueue at edge 0; cache_req high in cycle 1.
  - With gnt in cycle 1 and rvalid in cycle 2, ret_valid is high in cycle 3.
  - Minimum enqueue-to-retire is 3 cycles.
- Throughput: one enqueue, one issue and one retire per cycle sustained, given gnt and rvalid each cycle.
- Output types: ret_* are combinational from slot registers; cache_* are combinational from slot registers. Neither depends combinationally on any input.

## Structure
- Shared package nway_trace_repository_datatypes holds:
  - active_set_state_t, with encodings MAKE_REQUEST=0, WAIT_FOR_PROCESSING=1, REQUEST_RETIRED=2.
  - active_set_slot_t, a packed struct: occupied, state, mem_addr, trace_index, hit.
  - ACTIVE_SET_DEPTH default.
- Single module; no sub-module needed. The pointer/occupancy logic stays inline.

## Test plan
- Single entry, enqueue (idx 5, addr 0x1000); gnt in cycle 1; rvalid+hit in cycle 2 → ret_valid in cycle 3, ret_trace_index 5, ret_hit_miss 1; occupancy 1→0 on retire.
- Fill 4 entries with gnt held 0 → enq_ready 0 at occupancy 4; cache_addr stable at the first address across all stalled cycles.
- Back-to-back stream of 8 entries, gnt/rvalid always 1, ret_ready 1 → one retire per cycle. Trace indices come out in enqueue order; pointers wrap past 3→0 correctly.
- Responses alternate hit/miss with ret_ready held 0 for 5 cycles → entries held; flags retire in order 1,0,1,0 once ready is asserted.
- Full set with ret_ready=1 and enq_valid=1 in the same cycle → retire occurs, enqueue rejected; enqueue accepted the next cycle.
- rst_n pulsed low with 3 entries in flight → all outputs go to their reset values asynchronously; a following stray cache_rvalid produces no ret_valid.
